delta_controller_output_storer: RTL and testbench
=================================================

DELTA_CONTROLLER_OUTPUT_STORER -- requirements
Module: delta_controller_output_storer

Interface
REQ-001 SHALL have parameter MAX_OUTPUT_CHANNEL, default 256, the maximum output-channel count.
REQ-002 SHALL have parameter MAX_FEATURE_SIZE, default 256, the maximum output row/column size.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start_store, input, 1, a one-cycle store request.
REQ-006 SHALL have port OC_Num, input, clog2(MAX_OUTPUT_CHANNEL), the output-channel count.
REQ-007 SHALL have port RC_Size, input, clog2(MAX_FEATURE_SIZE), the output row/column size.
REQ-008 SHALL have port output_start_address, input, 32, the DRAM byte base address.
REQ-009 SHALL have port Output_SRAM_r_en, output, 1, the SRAM read request.
REQ-010 SHALL have port Output_SRAM_r_addr, output, 32, the SRAM element address.
REQ-011 SHALL have port Output_SRAM_r_d, input, 128, the SRAM read line.
REQ-012 SHALL have port Output_SRAM_d_ready, input, 1, marking Output_SRAM_r_d valid this cycle.
REQ-013 SHALL have port DRAM_Write, output, 1, the DRAM write request.
REQ-014 SHALL have port DRAM_Address, output, 32, the DRAM byte address.
REQ-015 SHALL have port DRAM_WriteData, output, 32, the DRAM write word.
REQ-016 SHALL have port DRAM_WriteDone, input, 1, marking the current word accepted this cycle.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port finished, output, 1, a one-cycle completion pulse.

Function
REQ-019 SHALL, on start_store sampled in IDLE, latch OC_eff = OC_Num and RC_eff = RC_Size, each with bits [2:0] cleared.
REQ-020 SHALL, in that same edge, load DRAM_Address with output_start_address and clear Output_SRAM_r_addr and the line counter.
REQ-021 SHALL write N = OC_eff*RC_eff*RC_eff/8 SRAM lines; each line is 8 elements and 4 DRAM words.
REQ-022 SHALL implement states IDLE, CHECK, RD_REQ, CAPTURE, WR0, WR1, WR2, WR3, ADVANCE and FINISH.
REQ-023 SHALL use transitions IDLE -start_store-> CHECK.
REQ-024 SHALL go CHECK -> FINISH when the line counter equals N, else CHECK -> RD_REQ.
REQ-025 SHALL hold RD_REQ until Output_SRAM_d_ready, then go to CAPTURE.
REQ-026 SHALL go CAPTURE -> WR0 unconditionally.
REQ-027 SHALL hold each WRk until DRAM_WriteDone, then go to WR(k+1); WR3 goes to ADVANCE.
REQ-028 SHALL go ADVANCE -> CHECK and FINISH -> IDLE unconditionally.
REQ-029 SHALL assert Output_SRAM_r_en only in RD_REQ and capture Output_SRAM_r_d into a 128-bit line register on the d_ready cycle.
REQ-030 SHALL assert DRAM_Write in WR0-WR3 continuously, with DRAM_WriteData = line[32k+31:32k] in WRk (word 0 = bits [31:0] first).
REQ-031 SHALL add 4 to DRAM_Address (mod 2^32) on every edge where a WRk state sees DRAM_WriteDone.
REQ-032 SHALL, in ADVANCE, add 8 to Output_SRAM_r_addr and 1 to the line counter.
REQ-033 SHALL hold address, data and request stable while waiting on d_ready or DRAM_WriteDone.
REQ-034 SHALL assert finished only in FINISH.
REQ-035 SHALL ignore start_store outside IDLE.
REQ-036 SHALL, with zero-wait inputs, spend 8 cycles per line; finished rises in cycle 2+8N after the start edge (cycle 0).
REQ-037 SHALL, when N = 0, go straight CHECK -> FINISH with no SRAM or DRAM request.
REQ-038 SHALL drive busy, finished, Output_SRAM_r_en and DRAM_Write as decodes of the registered state only.

Reset
REQ-039 SHALL, on reset assertion at any time including mid-transfer, immediately force state IDLE.
REQ-040 SHALL, on reset, immediately drive all outputs to 0, and clear the line register, line counter and addresses to 0.
REQ-041 SHALL retain no partial progress after reset; the next start_store restarts from SRAM address 0.

Verification
REQ-042 SHALL cover: OC=8, RC=8, base 0x1000, d_ready/WriteDone tied 1 -> 256 writes to 0x1000..0x13FC in word order, finished at cycle 514, busy low after.
REQ-043 SHALL cover: OC_Num=0, RC_Size=16 -> no r_en or DRAM_Write, finished at cycle 2.
REQ-044 SHALL cover: OC=13, RC=13 -> OC_eff=8, RC_eff=8, exactly 64 lines written.
REQ-045 SHALL cover: d_ready delayed 3 cycles and each WriteDone delayed 2 -> requests, addresses and data stable while waiting; per line 7+3+4*2 cycles.
REQ-046 SHALL cover: reset asserted during WR2 of line 5 -> DRAM_Write, busy and addresses 0 before the next edge; a restart rewrites from line 0.
REQ-047 SHALL cover: start_store pulsed during WR1 -> ignored, with transfer count and finished timing unchanged.

Source files
------------

// File: rtl/delta_controller_output_storer.sv
// Streams N = OC*RC*RC/8 lines from the output SRAM to DRAM. Each 128-bit line
// is written as four 32-bit words, lowest word first, at consecutive byte addresses.
module delta_controller_output_storer #(
    parameter int MAX_OUTPUT_CHANNEL = 256,
    parameter int MAX_FEATURE_SIZE   = 256
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start_store,
    input  logic [$clog2(MAX_OUTPUT_CHANNEL)-1:0] OC_Num,
    input  logic [$clog2(MAX_FEATURE_SIZE)-1:0]   RC_Size,
    input  logic [31:0]                           output_start_address,
    output logic                                  Output_SRAM_r_en,
    output logic [31:0]                           Output_SRAM_r_addr,
    input  logic [127:0]                          Output_SRAM_r_d,
    input  logic                                  Output_SRAM_d_ready,
    output logic                                  DRAM_Write,
    output logic [31:0]                           DRAM_Address,
    output logic [31:0]                           DRAM_WriteData,
    input  logic                                  DRAM_WriteDone,
    output logic                                  busy,
    output logic                                  finished
);

    localparam int OC_W = $clog2(MAX_OUTPUT_CHANNEL);
    localparam int RC_W = $clog2(MAX_FEATURE_SIZE);

    typedef enum logic [3:0] {
        IDLE, CHECK, RD_REQ, CAPTURE, WR0, WR1, WR2, WR3, ADVANCE, FINISH
    } state_t;

    state_t         state;
    logic [OC_W-1:0] oc_eff;
    logic [RC_W-1:0] rc_eff;
    logic [127:0]   line_q;
    logic [31:0]    line_cnt;
    logic [31:0]    sram_addr;
    logic [31:0]    dram_addr;
    logic [31:0]    n_lines;

    // Counts are rounded down to a multiple of 8 so every line is completely filled.
    assign n_lines = (32'(oc_eff) * 32'(rc_eff) * 32'(rc_eff)) >> 3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            oc_eff    <= '0;
            rc_eff    <= '0;
            line_q    <= '0;
            line_cnt  <= '0;
            sram_addr <= '0;
            dram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_store) begin
                        oc_eff    <= OC_Num & ~OC_W'(7);
                        rc_eff    <= RC_Size & ~RC_W'(7);
                        dram_addr <= output_start_address;
                        sram_addr <= '0;
                        line_cnt  <= '0;
                        state     <= CHECK;
                    end
                end
                CHECK:   state <= (line_cnt == n_lines) ? FINISH : RD_REQ;
                RD_REQ: begin
                    if (Output_SRAM_d_ready) begin
                        line_q <= Output_SRAM_r_d;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: state <= WR0;
                WR0, WR1, WR2, WR3: begin
                    if (DRAM_WriteDone) begin
                        dram_addr <= dram_addr + 32'd4;
                        case (state)
                            WR0:     state <= WR1;
                            WR1:     state <= WR2;
                            WR2:     state <= WR3;
                            default: state <= ADVANCE;
                        endcase
                    end
                end
                ADVANCE: begin
                    sram_addr <= sram_addr + 32'd8;
                    line_cnt  <= line_cnt + 32'd1;
                    state     <= CHECK;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        DRAM_WriteData = '0;
        case (state)
            WR0:     DRAM_WriteData = line_q[31:0];
            WR1:     DRAM_WriteData = line_q[63:32];
            WR2:     DRAM_WriteData = line_q[95:64];
            WR3:     DRAM_WriteData = line_q[127:96];
            default: DRAM_WriteData = '0;
        endcase
    end

    assign busy               = (state != IDLE);
    assign finished           = (state == FINISH);
    assign Output_SRAM_r_en   = (state == RD_REQ);
    assign DRAM_Write         = (state == WR0) || (state == WR1) ||
                                (state == WR2) || (state == WR3);
    assign Output_SRAM_r_addr = sram_addr;
    assign DRAM_Address       = dram_addr;

endmodule

// File: tb/tb_delta_controller_output_storer.sv
// Directed bench for delta_controller_output_storer with a reactive SRAM/DRAM model.
module tb_delta_controller_output_storer;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_store;
    logic [7:0]   OC_Num;
    logic [7:0]   RC_Size;
    logic [31:0]  output_start_address;
    logic         Output_SRAM_r_en;
    logic [31:0]  Output_SRAM_r_addr;
    logic [127:0] Output_SRAM_r_d;
    logic         Output_SRAM_d_ready;
    logic         DRAM_Write;
    logic [31:0]  DRAM_Address;
    logic [31:0]  DRAM_WriteData;
    logic         DRAM_WriteDone;
    logic         busy;
    logic         finished;

    always #5 clock = ~clock;

    delta_controller_output_storer dut (
        .clock                (clock),
        .reset                (reset),
        .start_store          (start_store),
        .OC_Num               (OC_Num),
        .RC_Size              (RC_Size),
        .output_start_address (output_start_address),
        .Output_SRAM_r_en     (Output_SRAM_r_en),
        .Output_SRAM_r_addr   (Output_SRAM_r_addr),
        .Output_SRAM_r_d      (Output_SRAM_r_d),
        .Output_SRAM_d_ready  (Output_SRAM_d_ready),
        .DRAM_Write           (DRAM_Write),
        .DRAM_Address         (DRAM_Address),
        .DRAM_WriteData       (DRAM_WriteData),
        .DRAM_WriteDone       (DRAM_WriteDone),
        .busy                 (busy),
        .finished             (finished)
    );

    int checks = 0;
    int failures = 0;

    // Memory model: tie=1 answers at once; otherwise each response arrives once
    // the request has already been held for rd_dly / wr_dly cycles.
    logic tie = 1'b1;
    int   rd_dly = 0;
    int   wr_dly = 0;
    int   rd_wait = 0;
    int   wr_wait = 0;
    int   cyc = 0;

    function automatic logic [31:0] sram_word(input logic [31:0] a, input int k);
        return {a[15:0], 8'hC5, 8'(k)};
    endfunction

    logic [127:0] line_model;
    assign line_model = {sram_word(Output_SRAM_r_addr, 3), sram_word(Output_SRAM_r_addr, 2),
                         sram_word(Output_SRAM_r_addr, 1), sram_word(Output_SRAM_r_addr, 0)};
    assign Output_SRAM_d_ready = tie ? 1'b1 : (Output_SRAM_r_en && rd_wait >= rd_dly);
    assign Output_SRAM_r_d     = Output_SRAM_d_ready ? line_model : ~line_model;
    assign DRAM_WriteDone      = tie ? 1'b1 : (DRAM_Write && wr_wait >= wr_dly);

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rd_wait <= (Output_SRAM_r_en && !Output_SRAM_d_ready) ? rd_wait + 1 : 0;
        wr_wait <= (DRAM_Write && !DRAM_WriteDone) ? wr_wait + 1 : 0;
    end

    // Write scoreboard and hold-stability monitor; the main sequence inspects its counters.
    int          wr_count = 0;
    int          rd_cycles = 0;
    int          wr_bad = 0;
    int          stab_bad = 0;
    int          wr_base = 0;
    logic [31:0] run_base = 32'h0;
    logic        prev_rd_wait = 1'b0;
    logic        prev_wr_wait = 1'b0;
    logic [31:0] prev_raddr = 32'h0;
    logic [31:0] prev_waddr = 32'h0;
    logic [31:0] prev_wdata = 32'h0;

    always @(negedge clock) begin
        if (reset) begin
            prev_rd_wait = 1'b0;
            prev_wr_wait = 1'b0;
        end else begin
            if (Output_SRAM_r_en) rd_cycles++;
            if (prev_rd_wait && !(Output_SRAM_r_en && Output_SRAM_r_addr == prev_raddr))
                stab_bad++;
            if (prev_wr_wait && !(DRAM_Write && DRAM_Address == prev_waddr &&
                                  DRAM_WriteData == prev_wdata))
                stab_bad++;
            if (DRAM_Write && DRAM_WriteDone) begin
                int idx;
                idx = wr_count - wr_base;
                if (DRAM_Address != run_base + 32'(4 * idx)) wr_bad++;
                if (DRAM_WriteData != sram_word(32'((idx / 4) * 8), idx % 4)) wr_bad++;
                wr_count++;
            end
            prev_rd_wait = Output_SRAM_r_en && !Output_SRAM_d_ready;
            prev_wr_wait = DRAM_Write && !DRAM_WriteDone;
            prev_raddr   = Output_SRAM_r_addr;
            prev_waddr   = DRAM_Address;
            prev_wdata   = DRAM_WriteData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int start_cyc = 0;
    int rd_base = 0;

    task automatic start_run(input logic [7:0] oc, input logic [7:0] rc, input logic [31:0] base);
        @(negedge clock);
        OC_Num = oc;
        RC_Size = rc;
        output_start_address = base;
        run_base = base;
        wr_base = wr_count;
        rd_base = rd_cycles;
        start_store = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clock);
        start_store = 1'b0;
    endtask

    // Returns the cycle index (start edge = cycle 0 end) in which finished is seen, or -1.
    task automatic wait_finish(output int fin_cycle);
        int guard;
        guard = 0;
        while (!finished && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        fin_cycle = finished ? (cyc - start_cyc + 1) : -1;
    endtask

    task automatic chk_idle_after(input string tag);
        @(negedge clock);
        chk({tag, "_finished_pulse"}, 32'(finished), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    int fc;

    initial begin
        reset = 1'b1;
        start_store = 1'b0;
        OC_Num = 8'd0;
        RC_Size = 8'd0;
        output_start_address = 32'h0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_r_en", 32'(Output_SRAM_r_en), 32'd0);
        chk("rst_dram_write", 32'(DRAM_Write), 32'd0);
        chk("rst_dram_addr", DRAM_Address, 32'd0);
        chk("rst_sram_addr", Output_SRAM_r_addr, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // OC=8 RC=8: 64 lines, 256 words from 0x1000, zero-wait memories
        start_run(8'd8, 8'd8, 32'h1000);
        wait_finish(fc);
        chk("t1_finish_cycle", 32'(fc), 32'd514);
        chk("t1_writes", 32'(wr_count - wr_base), 32'd256);
        chk("t1_reads", 32'(rd_cycles - rd_base), 32'd64);
        chk("t1_wr_mismatches", 32'(wr_bad), 32'd0);
        chk("t1_end_addr", DRAM_Address, 32'h1400);
        chk_idle_after("t1");

        // Zero channels: no traffic at all
        start_run(8'd0, 8'd16, 32'h2000);
        wait_finish(fc);
        chk("t2_finish_cycle", 32'(fc), 32'd2);
        chk("t2_writes", 32'(wr_count - wr_base), 32'd0);
        chk("t2_reads", 32'(rd_cycles - rd_base), 32'd0);
        chk_idle_after("t2");

        // 13 rounds down to 8 in both dimensions
        start_run(8'd13, 8'd13, 32'h3000);
        wait_finish(fc);
        chk("t3_finish_cycle", 32'(fc), 32'd514);
        chk("t3_writes", 32'(wr_count - wr_base), 32'd256);
        chk("t3_lines", 32'(rd_cycles - rd_base), 32'd64);
        chk("t3_wr_mismatches", 32'(wr_bad), 32'd0);

        // Slow memories: each line costs 1+3+1+4*3+1 = 18 cycles
        tie = 1'b0;
        rd_dly = 2;
        wr_dly = 2;
        start_run(8'd8, 8'd8, 32'h4000);
        wait_finish(fc);
        chk("t4_finish_cycle", 32'(fc), 32'd1154);
        chk("t4_writes", 32'(wr_count - wr_base), 32'd256);
        chk("t4_read_cycles", 32'(rd_cycles - rd_base), 32'd192);
        chk("t4_wr_mismatches", 32'(wr_bad), 32'd0);
        chk("t4_hold_violations", 32'(stab_bad), 32'd0);
        chk_idle_after("t4");
        tie = 1'b1;

        // Reset in WR2 of line 5 (word index 22), then restart from scratch
        start_run(8'd8, 8'd8, 32'h5000);
        begin
            int guard;
            guard = 0;
            do begin
                @(posedge clock);
                #2;
                guard++;
            end while (!((wr_count - wr_base) == 22 && DRAM_Write) && guard < 2000);
            chk("t5_reached_wr2_line5", 32'(wr_count - wr_base), 32'd22);
        end
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_dram_write", 32'(DRAM_Write), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_dram_addr", DRAM_Address, 32'd0);
        chk("t5_rst_sram_addr", Output_SRAM_r_addr, 32'd0);
        chk("t5_rst_wdata", DRAM_WriteData, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        start_run(8'd8, 8'd8, 32'h5000);
        wait_finish(fc);
        chk("t5_restart_finish_cycle", 32'(fc), 32'd514);
        chk("t5_restart_writes", 32'(wr_count - wr_base), 32'd256);
        chk("t5_wr_mismatches", 32'(wr_bad), 32'd0);

        // A second start with different inputs during WR1 must be ignored
        start_run(8'd8, 8'd8, 32'h6000);
        begin
            int guard;
            guard = 0;
            do begin
                @(posedge clock);
                #2;
                guard++;
            end while (!((wr_count - wr_base) == 1 && DRAM_Write) && guard < 2000);
        end
        OC_Num = 8'd0;
        output_start_address = 32'h9000;
        start_store = 1'b1;
        @(posedge clock);
        #2 start_store = 1'b0;
        wait_finish(fc);
        chk("t6_finish_cycle", 32'(fc), 32'd514);
        chk("t6_writes", 32'(wr_count - wr_base), 32'd256);
        chk("t6_wr_mismatches", 32'(wr_bad), 32'd0);
        chk_idle_after("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
